sram_resp: RTL and testbench

SRAM_RESP -- requirements
Module: sram_resp

---
 rtl/sram_resp_pkg.sv | 19 +
 rtl/sram_resp.sv | 131 +++++++++++++
 tb/tb_sram_resp.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_resp_pkg.sv
// Shared types and defaults for the SRAM response arbiter.
// Holds the state and response-owner encodings plus the default word-address width.
package sram_resp_pkg;

    localparam int SRAM_ADDR_W = 16;

    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_INST_PEND = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RESP_NONE    = 2'd0,
        RESP_INST    = 2'd1,
        RESP_DATA    = 2'd2,
        RESP_DATA_WR = 2'd3
    } resp_e;

endpackage

// File: rtl/sram_resp.sv
// Arbitrates core instruction/data ports onto one single-port RAM; 1-cycle read latency.
// Collisions serve data first, then stall one extra cycle for the deferred instruction read.
module sram_resp
    import sram_resp_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_sram_en,
    input  logic [3:0]        inst_sram_wen,
    input  logic [31:0]       inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic [31:0]       inst_sram_rdata,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [31:0]       data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    output logic              stallreq_for_mem,
    output logic              mem_en,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       conflict_cnt
);

    state_e              state_q, state_d;
    resp_e               resp_q, resp_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         inst_hold_q, inst_hold_d;
    logic [31:0]         data_hold_q, data_hold_d;
    logic [31:0]         conflict_cnt_q, conflict_cnt_d;

    logic                issue_en;
    logic [3:0]          issue_wen;
    logic                stall;
    logic [ADDR_W-1:0]   inst_word;
    logic [ADDR_W-1:0]   data_word;

    // Byte-offset bits, the instruction write path and high address bits are dropped.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wen, inst_sram_wdata,
                             inst_sram_addr[1:0], inst_sram_addr[31:ADDR_W+2],
                             data_sram_addr[1:0], data_sram_addr[31:ADDR_W+2]};

    assign inst_word = inst_sram_addr[ADDR_W+1:2];
    assign data_word = data_sram_addr[ADDR_W+1:2];

    always_comb begin
        state_d        = state_q;
        resp_d         = RESP_NONE;
        pend_addr_d    = pend_addr_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        conflict_cnt_d = conflict_cnt_q;
        issue_en       = 1'b0;
        issue_wen      = 4'h0;
        stall          = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (data_sram_en) begin
                    issue_en    = 1'b1;
                    issue_wen   = data_sram_wen;
                    mem_addr_d  = data_word;
                    mem_wdata_d = data_sram_wdata;
                    resp_d      = (data_sram_wen != 4'h0) ? RESP_DATA_WR : RESP_DATA;
                    if (inst_sram_en) begin
                        pend_addr_d = inst_word;
                        stall       = 1'b1;
                        state_d     = ST_INST_PEND;
                        if (conflict_cnt_q != 32'hFFFF_FFFF)
                            conflict_cnt_d = conflict_cnt_q + 32'd1;
                    end
                end else if (inst_sram_en) begin
                    issue_en   = 1'b1;
                    mem_addr_d = inst_word;
                    resp_d     = RESP_INST;
                end
            end
            ST_INST_PEND: begin
                issue_en   = 1'b1;
                mem_addr_d = pend_addr_q;
                resp_d     = RESP_INST;
                stall      = 1'b1;
                state_d    = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        inst_hold_d = (resp_q == RESP_INST) ? mem_rdata : inst_hold_q;
        data_hold_d = (resp_q == RESP_DATA) ? mem_rdata : data_hold_q;
    end

    // Reset masks every core-visible output in the same cycle it is asserted.
    assign mem_en           = issue_en & ~rst;
    assign mem_wen          = rst ? 4'h0 : issue_wen;
    assign mem_addr         = mem_addr_d;
    assign mem_wdata        = mem_wdata_d;
    assign stallreq_for_mem = stall & ~rst;
    assign inst_sram_rdata  = rst ? 32'h0 : inst_hold_d;
    assign data_sram_rdata  = rst ? 32'h0 : data_hold_d;
    assign conflict_cnt     = conflict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            resp_q         <= RESP_NONE;
            pend_addr_q    <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 32'h0;
            inst_hold_q    <= 32'h0;
            data_hold_q    <= 32'h0;
            conflict_cnt_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            resp_q         <= resp_d;
            pend_addr_q    <= pend_addr_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            inst_hold_q    <= inst_hold_d;
            data_hold_q    <= data_hold_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

endmodule

// File: tb/tb_sram_resp.sv
// Directed bench for sram_resp with a write-first, one-cycle-latency RAM model.
module tb_sram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq_for_mem;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] conflict_cnt;

    int tests  = 0;
    int errors = 0;

    logic [31:0] ram [0:65535];
    logic [31:0] ram_word;

    always #5 clk = ~clk;

    sram_resp #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .stallreq_for_mem(stallreq_for_mem),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    // Write-first backing RAM: read data of a write access is the merged new word.
    always @(posedge clk) begin
        if (mem_en) begin
            ram_word = ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_wen[b]) ram_word[8*b +: 8] = mem_wdata[8*b +: 8];
            ram[mem_addr] <= ram_word;
            mem_rdata     <= ram_word;
        end
    end

    task automatic idle();
        inst_sram_en = 1'b0; inst_sram_wen = 4'h0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
        data_sram_en = 1'b0; data_sram_wen = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        inst_sram_en = 1'b1; data_sram_en = 1'b1; data_sram_wen = 4'hF;
        #1;
        tests++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%0b exp=0", mem_en); end
        tests++; if (mem_wen !== 4'h0) begin errors++; $display("FAIL reset_mem_wen got=%h exp=0", mem_wen); end
        tests++; if (stallreq_for_mem !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stallreq_for_mem); end
        step(); step();
        rst = 1'b0;
        idle();
        #1;
        tests++; if (inst_sram_rdata !== 32'h0 || data_sram_rdata !== 32'h0)
            begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", inst_sram_rdata, data_sram_rdata); end
        tests++; if (conflict_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", conflict_cnt); end
    endtask

    task automatic test_inst_read();
        idle();
        inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0004; inst_sram_wen = 4'hF; inst_sram_wdata = 32'hFFFF_FFFF;
        #1;
        tests++; if (mem_en !== 1'b1 || mem_addr !== 16'h0001)
            begin errors++; $display("FAIL inst_issue got en=%0b addr=%h exp en=1 addr=0001", mem_en, mem_addr); end
        tests++; if (mem_wen !== 4'h0) begin errors++; $display("FAIL inst_no_write got=%h exp=0", mem_wen); end
        tests++; if (stallreq_for_mem !== 1'b0) begin errors++; $display("FAIL inst_stall got=%0b exp=0", stallreq_for_mem); end
        step();
        idle();
        #1;
        tests++; if (inst_sram_rdata !== 32'h2408_0001)
            begin errors++; $display("FAIL inst_rdata got=%h exp=24080001", inst_sram_rdata); end
        tests++; if (ram[1] !== 32'h2408_0001) begin errors++; $display("FAIL inst_ram_intact got=%h exp=24080001", ram[1]); end
    endtask

    task automatic test_data_write_read();
        idle();
        data_sram_en = 1'b1; data_sram_wen = 4'hF; data_sram_addr = 32'h10; data_sram_wdata = 32'hDEAD_BEEF;
        #1;
        tests++; if (mem_wen !== 4'hF || mem_addr !== 16'h0004)
            begin errors++; $display("FAIL dwr_issue got wen=%h addr=%h exp wen=f addr=0004", mem_wen, mem_addr); end
        step();
        idle();
        #1;
        tests++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL dwr_no_update got=%h exp=0", data_sram_rdata); end
        tests++; if (mem_en !== 1'b0 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 16'h0004)
            begin errors++; $display("FAIL idle_hold got en=%0b wd=%h addr=%h exp en=0 wd=deadbeef addr=0004", mem_en, mem_wdata, mem_addr); end
        data_sram_en = 1'b1; data_sram_addr = 32'h10;
        step();
        idle();
        #1;
        tests++; if (data_sram_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL drd_rdata got=%h exp=deadbeef", data_sram_rdata); end
    endtask

    task automatic test_byte_write();
        idle();
        data_sram_en = 1'b1; data_sram_wen = 4'h2; data_sram_addr = 32'h30; data_sram_wdata = 32'h0000_AB00;
        step();
        data_sram_wen = 4'h0; data_sram_wdata = 32'h0;
        step();
        idle();
        #1;
        tests++; if (data_sram_rdata !== 32'h1122_AB44) begin errors++; $display("FAIL byte_write got=%h exp=1122ab44", data_sram_rdata); end
    endtask

    task automatic test_conflict();
        idle();
        inst_sram_en = 1'b1; inst_sram_addr = 32'h0;
        data_sram_en = 1'b1; data_sram_addr = 32'h8;
        #1;
        tests++; if (stallreq_for_mem !== 1'b1 || mem_addr !== 16'h0002)
            begin errors++; $display("FAIL cfl_c0 got stall=%0b addr=%h exp stall=1 addr=0002", stallreq_for_mem, mem_addr); end
        step();
        idle();
        data_sram_en = 1'b1; data_sram_addr = 32'h40; data_sram_wen = 4'hF; data_sram_wdata = 32'h5555_5555;
        #1;
        tests++; if (stallreq_for_mem !== 1'b1 || mem_addr !== 16'h0000 || mem_wen !== 4'h0 || mem_en !== 1'b1)
            begin errors++; $display("FAIL cfl_c1 got stall=%0b addr=%h wen=%h en=%0b exp 1/0000/0/1", stallreq_for_mem, mem_addr, mem_wen, mem_en); end
        tests++; if (data_sram_rdata !== 32'hB2B2_B2B2) begin errors++; $display("FAIL cfl_data got=%h exp=b2b2b2b2", data_sram_rdata); end
        step();
        idle();
        #1;
        tests++; if (inst_sram_rdata !== 32'hA0A0_A0A0) begin errors++; $display("FAIL cfl_inst got=%h exp=a0a0a0a0", inst_sram_rdata); end
        tests++; if (stallreq_for_mem !== 1'b0) begin errors++; $display("FAIL cfl_release got=%0b exp=0", stallreq_for_mem); end
        tests++; if (conflict_cnt !== 32'h1) begin errors++; $display("FAIL cfl_cnt got=%h exp=1", conflict_cnt); end
        tests++; if (data_sram_rdata !== 32'hB2B2_B2B2 || ram[16] !== 32'h0)
            begin errors++; $display("FAIL cfl_ignored got=%h ram16=%h exp=b2b2b2b2/0", data_sram_rdata, ram[16]); end
    endtask

    task automatic test_rst_in_pend();
        idle();
        inst_sram_en = 1'b1; inst_sram_addr = 32'h20;
        data_sram_en = 1'b1; data_sram_addr = 32'h8;
        step();
        idle();
        rst = 1'b1;
        #1;
        tests++; if (mem_en !== 1'b0 || stallreq_for_mem !== 1'b0 || data_sram_rdata !== 32'h0)
            begin errors++; $display("FAIL rstp_during got en=%0b stall=%0b d=%h exp 0/0/0", mem_en, stallreq_for_mem, data_sram_rdata); end
        step();
        rst = 1'b0;
        #1;
        tests++; if (mem_en !== 1'b0 || stallreq_for_mem !== 1'b0)
            begin errors++; $display("FAIL rstp_after got en=%0b stall=%0b exp 0/0", mem_en, stallreq_for_mem); end
        tests++; if (inst_sram_rdata !== 32'h0 || data_sram_rdata !== 32'h0)
            begin errors++; $display("FAIL rstp_rdata got=%h/%h exp=0/0", inst_sram_rdata, data_sram_rdata); end
        tests++; if (conflict_cnt !== 32'h0) begin errors++; $display("FAIL rstp_cnt got=%h exp=0", conflict_cnt); end
        step();
        tests++; if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL rstp_no_resp got=%h exp=0", inst_sram_rdata); end
    endtask

    task automatic test_hold_and_wrap();
        idle();
        inst_sram_en = 1'b1; inst_sram_addr = 32'h20;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (inst_sram_rdata !== 32'h1234_5678)
                begin errors++; $display("FAIL hold_%0d got=%h exp=12345678", i, inst_sram_rdata); end
            step();
        end
        inst_sram_en = 1'b1; inst_sram_addr = 32'h0004_000B;
        #1;
        tests++; if (mem_addr !== 16'h0002) begin errors++; $display("FAIL wrap_addr got=%h exp=0002", mem_addr); end
        step();
        idle();
        #1;
        tests++; if (inst_sram_rdata !== 32'hB2B2_B2B2) begin errors++; $display("FAIL wrap_rdata got=%h exp=b2b2b2b2", inst_sram_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 32'h0;
        ram[0]  = 32'hA0A0_A0A0;
        ram[1]  = 32'h2408_0001;
        ram[2]  = 32'hB2B2_B2B2;
        ram[8]  = 32'h1234_5678;
        ram[12] = 32'h1122_3344;
        rst = 1'b1;
        idle();
        test_reset();
        test_inst_read();
        test_data_write_read();
        test_byte_write();
        test_conflict();
        test_rst_in_pend();
        test_hold_and_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
